// File: rtl/decode_order_arbiter.sv
// decode_order_arbiter
//
// Sequencing controller for the shared decode output mux. The A, B and D
// format decoders each own one holding entry. Every cycle the oldest valid
// entry (smallest major ID, then smallest minor ID, then A > B > D on an exact
// tie) is granted and its IDs are registered onto the mux select outputs.
// Decoders whose entry is valid but not granted are back-pressured.
//
// Ports
//   clock_i, reset_i         clock and synchronous active-high reset
//   flush_i                  drops every buffered entry and the inputs of that cycle
//   stall_i                  downstream stall: freezes outputs, suppresses grants
//   {A,B,D}enable_i          decoder presents a valid instruction
//   {A,B,D}MajId_i/MinId_i   IDs of the presented instruction
//   {A,B,D}stall_o           decoder must hold; its input is not accepted
//   enable_o                 granted instruction valid at the mux output
//   select_o                 mux source 0=A, 1=B, 2=D
//   majID_o, minID_o         IDs of the granted instruction
//   pending_o                number of valid holding entries

module decode_order_arbiter #(
  parameter int instructionCounterWidth = 64,
  parameter int instMinIdWidth          = 7
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
  input  logic                               flush_i,
  input  logic                               stall_i,
  input  logic                               Aenable_i,
  input  logic                               Benable_i,
  input  logic                               Denable_i,
  input  logic [instructionCounterWidth-1:0] AMajId_i,
  input  logic [instructionCounterWidth-1:0] BMajId_i,
  input  logic [instructionCounterWidth-1:0] DMajId_i,
  input  logic [instMinIdWidth-1:0]          AMinId_i,
  input  logic [instMinIdWidth-1:0]          BMinId_i,
  input  logic [instMinIdWidth-1:0]          DMinId_i,
  output logic                               Astall_o,
  output logic                               Bstall_o,
  output logic                               Dstall_o,
  output logic                               enable_o,
  output logic [1:0]                         select_o,
  output logic [instructionCounterWidth-1:0] majID_o,
  output logic [instMinIdWidth-1:0]          minID_o,
  output logic [1:0]                         pending_o
);

  localparam int keyWidth = instructionCounterWidth + instMinIdWidth;

  // Index 0 = A, 1 = B, 2 = D throughout.
  logic [2:0]                         valid;
  logic [2:0]                         portEnable;
  logic [2:0]                         win;
  logic [2:0]                         grant;
  logic [2:0]                         portStall;
  logic [2:0]                         accept;
  logic [instructionCounterWidth-1:0] majIn   [3];
  logic [instMinIdWidth-1:0]          minIn   [3];
  logic [instructionCounterWidth-1:0] majHold [3];
  logic [instMinIdWidth-1:0]          minHold [3];
  logic [keyWidth-1:0]                keyA, keyB, keyD;

  logic                               enableQ;
  logic [1:0]                         selectQ;
  logic [instructionCounterWidth-1:0] majQ;
  logic [instMinIdWidth-1:0]          minQ;
  logic [1:0]                         grantCode;
  logic [instructionCounterWidth-1:0] grantMaj;
  logic [instMinIdWidth-1:0]          grantMin;

  assign portEnable = {Denable_i, Benable_i, Aenable_i};
  assign majIn[0] = AMajId_i;
  assign majIn[1] = BMajId_i;
  assign majIn[2] = DMajId_i;
  assign minIn[0] = AMinId_i;
  assign minIn[1] = BMinId_i;
  assign minIn[2] = DMinId_i;

  // Concatenating major above minor makes a single unsigned compare give
  // the major-then-minor age order.
  assign keyA = {majHold[0], minHold[0]};
  assign keyB = {majHold[1], minHold[1]};
  assign keyD = {majHold[2], minHold[2]};

  // Ties go to the earlier port: A uses <= against both, B uses < against A
  // and <= against D, D uses < against both.
  assign win[0] = valid[0] & (~valid[1] | (keyA <= keyB)) & (~valid[2] | (keyA <= keyD));
  assign win[1] = valid[1] & (~valid[0] | (keyB <  keyA)) & (~valid[2] | (keyB <= keyD));
  assign win[2] = valid[2] & (~valid[0] | (keyD <  keyA)) & (~valid[1] | (keyD <  keyB));

  assign grant     = win & {3{~stall_i & ~flush_i}};
  assign portStall = valid & ~grant & {3{~flush_i}};
  // A granted port has portStall low, so it may refill on the same edge.
  assign accept    = portEnable & ~portStall & {3{~flush_i}};

  assign Astall_o = portStall[0];
  assign Bstall_o = portStall[1];
  assign Dstall_o = portStall[2];

  // Holding entries: a new accept wins over the clear from a grant.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      valid <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (flush_i) begin
          valid[i] <= 1'b0;
        end else if (accept[i]) begin
          valid[i]   <= 1'b1;
          majHold[i] <= majIn[i];
          minHold[i] <= minIn[i];
        end else if (grant[i]) begin
          valid[i] <= 1'b0;
        end
      end
    end
  end

  // Select the granted entry's code and IDs (grant is one-hot or zero).
  always_comb begin
    grantCode = 2'd0;
    grantMaj  = majHold[0];
    grantMin  = minHold[0];
    if (grant[1]) begin
      grantCode = 2'd1;
      grantMaj  = majHold[1];
      grantMin  = minHold[1];
    end else if (grant[2]) begin
      grantCode = 2'd2;
      grantMaj  = majHold[2];
      grantMin  = minHold[2];
    end
  end

  // Output registers: flush only drops enable, stall freezes everything,
  // an idle cycle drops enable but keeps the last select and IDs.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      enableQ <= 1'b0;
      selectQ <= 2'd0;
      majQ    <= '0;
      minQ    <= '0;
    end else if (flush_i) begin
      enableQ <= 1'b0;
    end else if (!stall_i) begin
      if (|grant) begin
        enableQ <= 1'b1;
        selectQ <= grantCode;
        majQ    <= grantMaj;
        minQ    <= grantMin;
      end else begin
        enableQ <= 1'b0;
      end
    end
  end

  assign enable_o  = enableQ;
  assign select_o  = selectQ;
  assign majID_o   = majQ;
  assign minID_o   = minQ;
  assign pending_o = {1'b0, valid[0]} + {1'b0, valid[1]} + {1'b0, valid[2]};

endmodule
